// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: pipeline hazard controller for the 5-stage MIPS core.
// Arbitrates multi-cycle EX ops, branch/jump flush, load-use and RAW stalls,
// and produces EX-stage forwarding selects plus a saturating stall counter.
// Build option: define FWD_EN to enable operand forwarding; when FWD_EN is
// undefined, forwarding selects are tied to 00 and RAW hazards stall instead.
// state_dbg exposes the FSM state for observation.
module hazard_ctrl_unit #(
  parameter int REG_AW      = 5,
  parameter int MC_LAT      = 4,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [REG_AW-1:0] IF_ID_Rs,
  input  logic [REG_AW-1:0] IF_ID_Rt,
  input  logic [REG_AW-1:0] ID_EX_Rs,
  input  logic [REG_AW-1:0] ID_EX_Rt,
  input  logic [REG_AW-1:0] ID_EX_Rd,
  input  logic [REG_AW-1:0] EX_MEM_Rd,
  input  logic [REG_AW-1:0] MEM_WB_Rd,
  input  logic              ID_EX_regWen,
  input  logic              EX_MEM_regWen,
  input  logic              MEM_WB_regWen,
  input  logic              ID_EX_memRead,
  input  logic              mc_start,
  input  logic              branch,
  input  logic              jump,
  output logic [3:0]        stall,
  output logic              flush,
  output logic              nop,
  output logic [1:0]        fwdA,
  output logic [1:0]        fwdB,
  output logic              mc_done,
  output logic [CNT_W-1:0]  stallCount,
  output logic [1:0]        state_dbg
);

`ifdef FWD_EN
  localparam logic FWD_ON = 1'b1;
`else
  localparam logic FWD_ON = 1'b0;
`endif

  // Counter must hold the larger of the two sequence reload values.
  localparam int MAXC = (MC_LAT > FLUSH_DEPTH) ? MC_LAT : FLUSH_DEPTH;
  localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);
  localparam logic [CW-1:0] MC_LOAD = CW'(MC_LAT - 1);
  localparam logic [CW-1:0] FL_LOAD = CW'(FLUSH_DEPTH - 1);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MC_WAIT = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    stall_c;
  logic          flush_c, nop_c, done_c;
  logic [1:0]    fwd_a_c, fwd_b_c;
  logic          load_use, raw_hit, raw_rs, raw_rt;

  // Load in EX whose destination is read by the instruction in ID.
  assign load_use = ID_EX_memRead && (ID_EX_Rt != '0) &&
                    ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));

  // Any in-flight writer matching an ID source; only stalls when forwarding is off.
  assign raw_rs = (IF_ID_Rs != '0) &&
                  ((ID_EX_regWen  && (ID_EX_Rd  == IF_ID_Rs)) ||
                   (EX_MEM_regWen && (EX_MEM_Rd == IF_ID_Rs)) ||
                   (MEM_WB_regWen && (MEM_WB_Rd == IF_ID_Rs)));
  assign raw_rt = (IF_ID_Rt != '0) &&
                  ((ID_EX_regWen  && (ID_EX_Rd  == IF_ID_Rt)) ||
                   (EX_MEM_regWen && (EX_MEM_Rd == IF_ID_Rt)) ||
                   (MEM_WB_regWen && (MEM_WB_Rd == IF_ID_Rt)));
  assign raw_hit = !FWD_ON && (raw_rs || raw_rt);

  // Forwarding selects; EX_MEM wins over MEM_WB on a double match.
  always_comb begin
    fwd_a_c = 2'b00;
    fwd_b_c = 2'b00;
    if (EX_MEM_regWen && (EX_MEM_Rd != '0) && (EX_MEM_Rd == ID_EX_Rs))
      fwd_a_c = 2'b10;
    else if (MEM_WB_regWen && (MEM_WB_Rd != '0) && (MEM_WB_Rd == ID_EX_Rs))
      fwd_a_c = 2'b01;
    if (EX_MEM_regWen && (EX_MEM_Rd != '0) && (EX_MEM_Rd == ID_EX_Rt))
      fwd_b_c = 2'b10;
    else if (MEM_WB_regWen && (MEM_WB_Rd != '0) && (MEM_WB_Rd == ID_EX_Rt))
      fwd_b_c = 2'b01;
  end

  // FSM next state and per-state control outputs.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_c   = 4'b0000;
    flush_c   = 1'b0;
    nop_c     = 1'b0;
    done_c    = 1'b0;
    case (state)
      ST_RUN: begin
        if (mc_start) begin
          // A concurrent branch is left in IF_ID and re-presented later.
          stall_c = 4'b0111;
          if (MC_LAT == 1) begin
            done_c = 1'b1;
          end else begin
            state_nxt = ST_MC_WAIT;
            cnt_nxt   = MC_LOAD;
          end
        end else if (branch || jump) begin
          flush_c = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            state_nxt = ST_FLUSH;
            cnt_nxt   = FL_LOAD;
          end
        end else if (load_use || raw_hit) begin
          stall_c = 4'b0011;
          nop_c   = 1'b1;
        end
      end
      ST_MC_WAIT: begin
        stall_c = 4'b0111;
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          done_c    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        flush_c = 1'b1;
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and sequence counter registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs are forced low while reset is held.
  assign stall     = Rst ? stall_c : 4'b0000;
  assign flush     = Rst && flush_c;
  assign nop       = Rst && nop_c;
  assign mc_done   = Rst && done_c;
  assign fwdA      = (Rst && FWD_ON) ? fwd_a_c : 2'b00;
  assign fwdB      = (Rst && FWD_ON) ? fwd_b_c : 2'b00;
  assign state_dbg = state;

  // Saturating count of cycles where the PC is held.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)
      stallCount <= '0;
    else if (stall[0] && (stallCount != {CNT_W{1'b1}}))
      stallCount <= stallCount + CNT_W'(1);
  end

endmodule
